// File: rtl/riscp_pkg.sv
// Shared RISC core definitions: data/address widths, register-index and word types.
package riscp_pkg;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module reg_scoreboard
  import riscp_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      iss_valid,
  input  reg_addr_t iss_rd,
  input  logic      we,
  input  reg_addr_t wr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_pend,
  output logic      rs2_pend
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Clear on writeback first, then set on issue so a same-register issue wins.
  always_comb begin
    pending_d = pending_q;
    if (we && (wr_addr != REG_ZERO)) begin
      pending_d[wr_addr] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (iss_valid && (iss_rd != REG_ZERO)) begin
      pending_d[iss_rd] = 1'b1;
    end else begin
      pending_d[REG_ZERO] = 1'b0;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  // Pending-bit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= {NREGS{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs1_pend = pending_q[rs1_addr];
  assign rs2_pend = pending_q[rs2_addr];

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 architectural register file, 2 read / 1 write, with pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on both read ports.
module reg_file_wb
  import riscp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd
);

  word_t regs_q [NREGS];
  word_t regs_d [NREGS];
  logic  wr_en;
  logic  rs1_pend;
  logic  rs2_pend;
  logic  rs1_fwd;
  logic  rs2_fwd;

  assign wr_en = we && (wr_addr != REG_ZERO);

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .we        (we),
    .wr_addr   (wr_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_pend  (rs1_pend),
    .rs2_pend  (rs2_pend)
  );

  // Next-state of the storage array; x0 is held at zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
    end else begin
      regs_d = regs_q;
    end
    regs_d[REG_ZERO] = {XLEN{1'b0}};
  end

  // Storage array state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read muxes; a forwarded write also hides the pending bit.
  always_comb begin
    rs1_fwd = 1'b0;
    rs2_fwd = 1'b0;
`ifdef REGFILE_BYPASS_EN
    rs1_fwd = wr_en && (wr_addr == rs1_addr);
    rs2_fwd = wr_en && (wr_addr == rs2_addr);
`endif
    if (rs1_addr == REG_ZERO) begin
      rs1_data = {XLEN{1'b0}};
    end else if (rs1_fwd) begin
      rs1_data = wr_data;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
    if (rs2_addr == REG_ZERO) begin
      rs2_data = {XLEN{1'b0}};
    end else if (rs2_fwd) begin
      rs2_data = wr_data;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
    rs1_busy = rs1_pend && !rs1_fwd;
    rs2_busy = rs2_pend && !rs2_fwd;
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed vector table, mid-run reset, randomized model check.
module tb_reg_file_wb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
  logic [31:0] rs1_data, rs2_data, wr_data;
  logic        rs1_busy, rs2_busy, we, iss_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg  [32];
  bit          m_pend [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1d;
    logic [31:0] e2d;
    logic        e1b;
    logic        e2b;
  } vec_t;

  vec_t tbl [16];

  reg_file_wb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [4:0] rd,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] e1d, input logic [31:0] e2d,
                              input logic e1b, input logic e2b);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = wd; v.iv = iv; v.rd = rd; v.a1 = a1; v.a2 = a2;
    v.e1d = e1d; v.e2d = e2d; v.e1b = e1b; v.e2b = e2b;
    return v;
  endfunction

  task automatic idle();
    we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; iss_valid = 1'b0; iss_rd = 5'd0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // Expected read data from the architectural rules.
  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && we && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (BYP && we && wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    #2;
    check("reset_rs1_data", rs1_data, 32'd0);
    check("reset_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl[0]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    tbl[1]  = mk(0, 0, 32'd0, 1, 0, 0, 0, 32'd0, 32'd0, 0, 0);
    tbl[2]  = mk(1, 7, 32'hDEAD_BEEF, 0, 0, 0, 7, 32'd0, BYP ? 32'hDEAD_BEEF : 32'd0, 0, 0);
    tbl[3]  = mk(0, 0, 32'd0, 0, 0, 0, 7, 32'd0, 32'hDEAD_BEEF, 0, 0);
    tbl[4]  = mk(0, 0, 32'd0, 1, 3, 3, 0, 32'd0, 32'd0, 0, 0);
    tbl[5]  = mk(0, 0, 32'd0, 0, 0, 3, 0, 32'd0, 32'd0, 1, 0);
    tbl[6]  = mk(0, 0, 32'd0, 0, 0, 3, 0, 32'd0, 32'd0, 1, 0);
    tbl[7]  = mk(1, 3, 32'h42, 0, 0, 3, 0, BYP ? 32'h42 : 32'd0, 32'd0, !BYP, 0);
    tbl[8]  = mk(0, 0, 32'd0, 0, 0, 3, 0, 32'h42, 32'd0, 0, 0);
    tbl[9]  = mk(1, 9, 32'h99, 1, 9, 9, 0, BYP ? 32'h99 : 32'd0, 32'd0, 0, 0);
    tbl[10] = mk(0, 0, 32'd0, 0, 0, 9, 9, 32'h99, 32'h99, 1, 1);
    tbl[11] = mk(0, 0, 32'd0, 1, 6, 6, 0, 32'd0, 32'd0, 0, 0);
    tbl[12] = mk(1, 6, 32'h66, 1, 4, 4, 6, 32'd0, BYP ? 32'h66 : 32'd0, 0, !BYP);
    tbl[13] = mk(0, 0, 32'd0, 0, 0, 4, 6, 32'd0, 32'h66, 1, 0);
    tbl[14] = mk(1, 9, 32'h123, 0, 0, 9, 4, BYP ? 32'h123 : 32'h99, 32'd0, !BYP, 1);
    tbl[15] = mk(0, 0, 32'd0, 0, 0, 9, 0, 32'h123, 32'd0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      we = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      iss_valid = tbl[i].iv; iss_rd = tbl[i].rd;
      rs1_addr = tbl[i].a1; rs2_addr = tbl[i].a2;
      @(negedge clk);
      check($sformatf("vec%0d_rs1_data", i), rs1_data, tbl[i].e1d);
      check($sformatf("vec%0d_rs2_data", i), rs2_data, tbl[i].e2d);
      check($sformatf("vec%0d_rs1_busy", i), {31'd0, rs1_busy}, {31'd0, tbl[i].e1b});
      check($sformatf("vec%0d_rs2_busy", i), {31'd0, rs2_busy}, {31'd0, tbl[i].e2b});
      @(posedge clk); #1;
    end

    // Mid-run asynchronous reset with x5 written and pending, x4 still stalled.
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234; iss_valid = 1'b1; iss_rd = 5'd5;
    rs1_addr = 5'd5; rs2_addr = 5'd4;
    @(posedge clk); #1;
    idle();
    #1;
    check("pre_reset_x5_data", rs1_data, 32'h1234);
    check("pre_reset_x5_busy", {31'd0, rs1_busy}, 32'd1);
    check("pre_reset_x4_busy", {31'd0, rs2_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_x5_data", rs1_data, 32'd0);
    check("async_reset_x5_busy", {31'd0, rs1_busy}, 32'd0);
    check("async_reset_x4_busy", {31'd0, rs2_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_x5_data", rs1_data, 32'd0);
    @(posedge clk); #1;

    for (int r = 0; r < 32; r++) begin
      m_reg[r] = 32'd0;
      m_pend[r] = 1'b0;
    end

    for (int c = 0; c < 400; c++) begin
      we = 1'($urandom_range(0, 1)); wr_addr = rand_addr(); wr_data = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = rand_addr();
      rs1_addr = rand_addr(); rs2_addr = rand_addr();
      @(negedge clk);
      check("rnd_rs1_data", rs1_data, exp_data(rs1_addr));
      check("rnd_rs2_data", rs2_data, exp_data(rs2_addr));
      check("rnd_rs1_busy", {31'd0, rs1_busy}, {31'd0, exp_busy(rs1_addr)});
      check("rnd_rs2_busy", {31'd0, rs2_busy}, {31'd0, exp_busy(rs2_addr)});
      @(posedge clk);
      if (we && wr_addr != 5'd0) begin
        m_reg[wr_addr] = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural register file of the 32-bit RISC core: 32 x 32-bit registers, two read ports and one write port.
- Sits directly downstream of the writeback 2:1 select (ALU result vs. load data); that select's 32-bit output drives wr_data.
- Read ports feed the decode/operand stage.
- Includes a pending-write scoreboard so decode can detect read-after-write hazards on in-flight destinations.

Parameters:
- XLEN, 32, data width of each register and port.
- NREGS, 32, number of registers; must be a power of 2.
- AW, 5, register address width, equal to log2(NREGS).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs1_addr  input  AW  read port 1 address.
- rs2_addr  input  AW  read port 2 address.
- rs1_data  output  XLEN  read port 1 data.
- rs2_data  output  XLEN  read port 2 data.
- rs1_busy  output  1  rs1_addr has a pending write.
- rs2_busy  output  1  rs2_addr has a pending write.
- we  input  1  writeback enable.
- wr_addr  input  AW  writeback destination.
- wr_data  input  XLEN  writeback data, driven by the writeback select output.
- iss_valid  input  1  an instruction with a destination register issues this cycle.
- iss_rd  input  AW  destination register of the issuing instruction.

Behaviour:
- Reset
  - When rst_n = 0, asynchronously clear all registers to 0 and all pending bits to 0.
  - Reads during and after reset return 0; rs1_busy and rs2_busy are 0.
  - A reset in the middle of a stall clears every pending bit, which releases the stall.
- Write
  - When we = 1 and wr_addr != 0, write wr_data to reg[wr_addr] on the rising edge.
  - Writes to x0 are discarded.
- Read
  - Reads are combinational: rsN_data = reg[rsN_addr], with 0 latency.
  - Address 0 always reads 0.
  - Without the bypass feature, a read of a register in the same cycle as its write returns the old value; the new value is visible from the next cycle.
- Scoreboard (one pending bit per register; bit 0 is tied to 0)
  - Set: iss_valid = 1 and iss_rd != 0 sets pending[iss_rd] on the edge.
  - Clear: we = 1 and wr_addr != 0 clears pending[wr_addr] on the edge.
  - If set and clear target the same register in the same cycle, set wins and the bit stays 1: a new producer has issued.
  - Set and clear on different registers both take effect.
  - A clear on a register whose pending bit is 0 is legal and has no effect.
  - Issue to a register that is already pending leaves it pending; there is no counting, because the pipeline guarantees in-order writeback.
- Busy outputs
  - rsN_busy = pending[rsN_addr] is combinational.
  - Without the bypass feature, busy stays 1 in the writeback cycle itself.
- Widths
  - Indices wider than AW bits are not possible by construction.
  - No arithmetic is performed; data is stored as-is.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- With the macro defined:
  - When we = 1, wr_addr != 0 and wr_addr == rsN_addr, rsN_data = wr_data in the same cycle (write-through forwarding).
  - rsN_busy is forced to 0 for that port in that cycle, even if pending is 1.
  - Address 0 still reads 0 with busy 0.
- Without the macro:
  - No forwarding; old data is returned as described under Read.
  - Busy reflects the pending bits only.

Decomposition:
- Shared package riscp_pkg holds:
  - XLEN = 32, AW = 5, NREGS = 32;
  - typedef reg_addr_t = logic [AW-1:0];
  - typedef word_t = logic [XLEN-1:0];
  - constant REG_ZERO = 0.
- One natural sub-module, reg_scoreboard: the pending-bit vector, the set/clear priority, and the busy lookups.
- The storage array and read muxing stay in the top module.

Test Plan:
1. Reset check:
   - Stimulus: assert rst_n = 0 mid-run, with reg[5] = 32'h1234 and pending[5] = 1.
   - Response: rs1_addr = 5 reads 0 immediately and rs1_busy = 0, before any clock edge.
2. x0 protection:
   - Stimulus: we = 1, wr_addr = 0, wr_data = 32'hFFFF_FFFF; then iss_valid = 1, iss_rd = 0.
   - Response: rs1_addr = 0 reads 0 and rs1_busy = 0 throughout.
3. Write/read:
   - Stimulus: write 32'hDEAD_BEEF to x7; in the same cycle rs2_addr = 7.
   - Response without bypass: rs2_data = old value (0) that cycle, 32'hDEAD_BEEF the next cycle.
   - Response with REGFILE_BYPASS_EN: 32'hDEAD_BEEF in the same cycle.
4. Scoreboard lifecycle:
   - Stimulus: issue rd = 3, wait 2 cycles, then writeback x3 = 32'h42.
   - Response: rs1_busy (rs1_addr = 3) is 1 from the cycle after issue through the writeback cycle (0 in that cycle with bypass), then 0; rs1_data = 32'h42.
5. Simultaneous set/clear, same register:
   - Stimulus: issue rd = 9 and writeback x9 in the same cycle.
   - Response: pending[9] remains 1 afterwards.
6. Simultaneous set/clear, different registers:
   - Stimulus: issue rd = 4 while writing back x6 (pending).
   - Response: pending[4] = 1 and pending[6] = 0 next cycle.
